// File: rtl/stream_pkg.sv
// Shared types, default sizes and the read-credit helper for the RAM word streamer.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    localparam int unsigned RAM_DEPTH     = 328;
    localparam int unsigned STREAM_ADDR_W = 32;
    localparam int unsigned STREAM_DATA_W = 32;

    // A new read may launch only if every word already owed to the stream,
    // plus this one, still fits in the 2-entry buffer after this cycle's pop.
    function automatic logic has_credit(input logic [1:0] buf_count,
                                        input logic       addr_vld,
                                        input logic       data_vld,
                                        input logic       pop);
        logic [2:0] owed;
        logic [2:0] room;
        owed = {1'b0, buf_count} + {2'b00, addr_vld} + {2'b00, data_vld};
        room = 3'd2 + {2'b00, pop};
        return (owed < room);
    endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO; push and pop in the same cycle keep the count and order.
module word_fifo2
    import stream_pkg::*;
#(
    parameter int unsigned DATA_W = STREAM_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] slot_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign empty     = (count_r == 2'd0);
    assign full      = (count_r == 2'd2);
    assign count     = count_r;
    assign dout      = slot_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage and pointers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_r[0] <= {DATA_W{1'b0}};
            slot_r[1] <= {DATA_W{1'b0}};
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
        end else begin
            if (do_push_s) begin
                slot_r[wr_ptr_r] <= din;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

    // Occupancy count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= 2'd0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ram_word_streamer.sv
// Streams RAM words base_addr..base_addr+length-1 onto a valid/ready port at up to one per cycle.
// Define STREAM_TERM_EN to end a job early on the first captured word equal to TERM_WORD.
module ram_word_streamer
    import stream_pkg::*;
#(
    parameter int unsigned       ADDR_W    = STREAM_ADDR_W,
    parameter int unsigned       DATA_W    = STREAM_DATA_W,
    parameter int unsigned       DEPTH     = RAM_DEPTH,
    parameter logic [DATA_W-1:0] TERM_WORD = {DATA_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef STREAM_TERM_EN
    localparam logic TERM_EN = 1'b1;
`else
    localparam logic TERM_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE_C   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    state_e            state_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] remain_r;
    logic              addr_vld_r;
    logic              inflight_r;
    logic              term_seen_r;
    logic              err_r;

    logic [ADDR_W:0]   end_addr_s;
    logic              range_bad_s;
    logic              len_zero_s;
    logic              len_one_s;
    logic              accept_s;
    logic              launch_s;
    logic              issue_s;
    logic              term_hit_s;
    logic              data_vld_s;
    logic              pop_s;
    logic              drained_s;
    logic [2:0]        hold_s;

    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic [DATA_W-1:0] fifo_dout_s;
    logic [1:0]        fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    // The range sum is one bit wider so a huge base cannot wrap into a legal window.
    assign end_addr_s  = {1'b0, base_addr} + {1'b0, length};
    assign range_bad_s = (end_addr_s > DEPTH_C);
    assign len_zero_s  = (length == {ADDR_W{1'b0}});
    assign len_one_s   = (length == ONE_C);
    assign accept_s    = (state_r == IDLE) & start;
    assign launch_s    = accept_s & ~len_zero_s & ~range_bad_s;

    // Once a terminator is seen, every later RAM return belongs to a dead job.
    assign term_hit_s  = TERM_EN & inflight_r & ~term_seen_r & (mem_q == TERM_WORD);
    assign data_vld_s  = inflight_r & ~term_seen_r & ~term_hit_s;

    assign pop_s       = out_valid & out_ready;
    assign fifo_pop_s  = out_ready & ~fifo_empty_s;
    assign fifo_push_s = data_vld_s & ~(fifo_empty_s & out_ready);

    assign issue_s     = (state_r == RUN) & ~term_hit_s
                       & has_credit(fifo_count_s, addr_vld_r, data_vld_s, pop_s)
                       & (~fifo_full_s | fifo_pop_s);

    assign hold_s      = {1'b0, fifo_count_s} + {2'b00, data_vld_s};
    assign drained_s   = (hold_s == {2'b00, pop_s})
                       & (~addr_vld_r | term_seen_r | term_hit_s);

    word_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push_s),
        .pop     (fifo_pop_s),
        .din     (mem_q),
        .dout    (fifo_dout_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!start) begin
                    state_nxt_s = IDLE;
                end else if (len_zero_s || range_bad_s) begin
                    state_nxt_s = FIN;
                end else if (len_one_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RUN: begin
                if (term_hit_s || (issue_s && (remain_r == ONE_C))) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (drained_s) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_r != IDLE);
        done = (state_r == FIN);
        err  = (state_r == FIN) & err_r;
    end

    // Read address, words left to issue, and "address on the bus is a real read"
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr_r <= {ADDR_W{1'b0}};
            remain_r   <= {ADDR_W{1'b0}};
            addr_vld_r <= 1'b0;
        end else if (launch_s) begin
            mem_addr_r <= base_addr;
            remain_r   <= length - ONE_C;
            addr_vld_r <= 1'b1;
        end else if (issue_s) begin
            mem_addr_r <= mem_addr_r + ONE_C;
            remain_r   <= remain_r - ONE_C;
            addr_vld_r <= 1'b1;
        end else begin
            addr_vld_r <= 1'b0;
        end
    end

    // RAM return tracking, terminator latch and error flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r  <= 1'b0;
            term_seen_r <= 1'b0;
            err_r       <= 1'b0;
        end else if (accept_s) begin
            inflight_r  <= addr_vld_r;
            term_seen_r <= 1'b0;
            err_r       <= range_bad_s & ~len_zero_s;
        end else begin
            inflight_r  <= addr_vld_r;
            term_seen_r <= term_seen_r | term_hit_s;
            err_r       <= err_r;
        end
    end

    // Older buffered words go first; an empty buffer lets the fresh RAM word straight through.
    always_comb begin
        out_valid = ~fifo_empty_s | data_vld_s;
        if (!fifo_empty_s) begin
            out_data = fifo_dout_s;
        end else if (data_vld_s) begin
            out_data = mem_q;
        end else begin
            out_data = {DATA_W{1'b0}};
        end
    end

    assign mem_addr = mem_addr_r;
    assign mem_wren = 1'b0;

endmodule

// File: tb/tb_ram_word_streamer.sv
// Table-driven bench for ram_word_streamer with a registered-read RAM model and a word scoreboard.
module tb_ram_word_streamer;

    localparam int DEPTH = 328;

    typedef struct {
        logic [31:0] base;
        logic [31:0] len;
        bit          toggle;
        bit          restart;
        int          exp_done;
        bit          exp_err;
        int          exp_words;
        int          exp_first;
        logic [31:0] exp_end_addr;
    } job_t;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        start     = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [31:0] length    = 32'd0;
    logic [31:0] mem_addr;
    logic        mem_wren;
    logic [31:0] mem_q     = 32'd0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] ram [DEPTH];
    logic [31:0] exp_q [$];
    job_t        jobs [10];
    int          checks   = 0;
    int          failures = 0;

    ram_word_streamer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .mem_addr  (mem_addr),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    // One-cycle registered read, like the real data RAM
    always @(posedge clock) begin
        if (mem_addr < 32'(DEPTH)) mem_q <= ram[mem_addr[8:0]];
        else                       mem_q <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input job_t j);
        int   words     = 0;
        int   done_cyc  = -1;
        int   first_cyc = -1;
        int   done_cnt  = 0;
        int   outst;
        logic err_at_done = 1'b0;
        exp_q.delete();
        for (int k = 0; k < j.exp_words; k++) exp_q.push_back(ram[int'(j.base) + k]);
        @(posedge clock); #1;
        start = 1'b1; base_addr = j.base; length = j.len; out_ready = 1'b1;
        @(negedge clock);
        check("wren_c0", 64'(mem_wren), 64'd0);
        for (int cyc = 1; cyc < 60; cyc++) begin
            @(posedge clock); #1;
            start = (j.restart && cyc == 2);
            if (j.restart && cyc == 2) base_addr = 32'd200;
            out_ready = j.toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clock);
            check("mem_wren", 64'(mem_wren), 64'd0);
            check("err_with_done", 64'(err), 64'(done & j.exp_err));
            if (j.exp_words > 0 && busy && !done) begin
                outst = int'(mem_addr - j.base) + 1 - words;
                check("outstanding_le2", 64'(outst <= 2), 64'd1);
            end
            if (exp_q.size() == 0) begin
                check("valid_when_none_left", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                check("word", 64'(out_data), 64'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    words++;
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = cyc;
                    err_at_done = err;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        check("done_cycle", 64'(done_cyc), 64'(j.exp_done));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("err_at_done", 64'(err_at_done), 64'(j.exp_err));
        check("word_count", 64'(words), 64'(j.exp_words));
        check("first_valid_cycle", 64'(first_cyc), 64'(j.exp_first));
        check("end_mem_addr", 64'(mem_addr), 64'(j.exp_end_addr));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'hD000_0000 + 32'(i) * 32'h0001_0003;
        ram[5] = 32'h0000_0000;

        //            base          len    tog   rst   done err  words first end
        jobs[0] = '{32'd0,        32'd4, 1'b0, 1'b0,  6, 1'b0, 4,  2, 32'd3};
        jobs[1] = '{32'd10,       32'd6, 1'b1, 1'b0, 13, 1'b0, 6,  2, 32'd15};
        jobs[2] = '{32'd7,        32'd0, 1'b0, 1'b0,  1, 1'b0, 0, -1, 32'd15};
        jobs[3] = '{32'd320,      32'd9, 1'b0, 1'b0,  1, 1'b1, 0, -1, 32'd15};
        jobs[4] = '{32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1, 1'b1, 0, -1, 32'd15};
        jobs[5] = '{32'd324,      32'd4, 1'b0, 1'b0,  6, 1'b0, 4,  2, 32'd327};
        jobs[6] = '{32'd100,      32'd1, 1'b0, 1'b0,  3, 1'b0, 1,  2, 32'd100};
        jobs[7] = '{32'd20,       32'd3, 1'b0, 1'b1,  5, 1'b0, 3,  2, 32'd22};
`ifdef STREAM_TERM_EN
        jobs[8] = '{32'd3,        32'd8, 1'b0, 1'b0,  6, 1'b0, 2,  2, 32'd6};
`else
        jobs[8] = '{32'd3,        32'd8, 1'b0, 1'b0, 10, 1'b0, 8,  2, 32'd10};
`endif
        jobs[9] = '{32'd50,       32'd3, 1'b0, 1'b0,  5, 1'b0, 3,  2, 32'd52};

        repeat (3) @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wren", 64'(mem_wren), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        reset_n = 1'b1;

        for (int n = 0; n < 9; n++) run_job(jobs[n]);

        // Reset in the middle of a job after two words have gone out
        @(posedge clock); #1;
        start = 1'b1; base_addr = 32'd40; length = 32'd10; out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); @(negedge clock);
        check("mid_valid0", 64'(out_valid), 64'd1);
        check("mid_word0", 64'(out_data), 64'(ram[40]));
        @(posedge clock); @(negedge clock);
        check("mid_valid1", 64'(out_valid), 64'd1);
        check("mid_word1", 64'(out_data), 64'(ram[41]));
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_mem_addr", 64'(mem_addr), 64'd0);
        check("arst_done_err", 64'({done, err}), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        run_job(jobs[9]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
